// File: rtl/mem_sequencer_pkg.sv
// mem_sequencer_pkg
//   Shared definitions for the fetch/execute sequencer: the 3-bit opcode
//   set, the eight phase encodings of one instruction cycle, and the
//   decode helper that picks out opcodes which read an operand from memory.
package mem_sequencer_pkg;

  localparam int OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/mem_sequencer_pc_counter.sv
// pc_counter
//   Program counter register with synchronous active-low reset.
//   Ports:
//     clk          system clock
//     rst_n        synchronous active-low reset (clears to 0)
//     inc_i        advance by one, wrapping at the top of the range
//     load_i       load load_data_i (takes priority over inc_i)
//     load_data_i  jump target
//     pc_o         current count
module pc_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic [WIDTH-1:0] pc_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_data_i;
    end else if (inc_i) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer
//   Fetch/execute sequencer in front of a 32x8 instruction/data memory.
//   Holds PC and IR and steps an 8-phase cycle per instruction; all outputs
//   decode combinationally from phase, IR, PC and the zero flag.
//   Ports:
//     clk       system clock
//     rst_n     synchronous active-low reset
//     zero      accumulator-is-zero flag (used by SKZ)
//     acc_in    accumulator value driven onto the bus by STO
//     mem_addr  memory address (PC in phases 0-3, IR operand in 4-7)
//     mem_rd    memory read enable (memory drives the bus)
//     mem_wr    memory write enable (memory captures on rising edge)
//     mem_data  shared tri-state data bus
//     opcode    IR opcode field for the ALU
//     ld_ac     accumulator load strobe
//     halt      processor halted
//     pc        current PC (debug)
//     phase     current phase (debug)
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  zero,
  input  logic [DATA_WIDTH-1:0] acc_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic [2:0]            opcode,
  output logic                  ld_ac,
  output logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [2:0]            phase
);

  phase_e                phase_q, phase_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  opcode_e               op;
  logic                  aluop;
  logic                  pc_inc;
  logic                  pc_load;
  logic                  bus_drive;
  logic [ADDR_WIDTH-1:0] pc_cur;

  assign op    = opcode_e'(ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]);
  assign aluop = is_aluop(op);

  // Next-state: phase advance (frozen at OP_ADDR on HLT) and IR capture.
  always_comb begin
    phase_d = phase_e'(phase_q + 3'd1);
    ir_d    = ir_q;
    if (phase_q == OP_ADDR && op == OP_HLT) begin
      phase_d = OP_ADDR;
    end
    if (phase_q == INST_LOAD) begin
      ir_d = mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= INST_ADDR;
      ir_q    <= '0;
    end else begin
      phase_q <= phase_d;
      ir_q    <= ir_d;
    end
  end

  // Output decode.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    ld_ac     = 1'b0;
    halt      = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    bus_drive = 1'b0;
    unique case (phase_q)
      INST_ADDR: ;
      INST_FETCH, INST_LOAD, IDLE: mem_rd = 1'b1;
      OP_ADDR: begin
        if (op == OP_HLT) begin
          halt = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd    = aluop;
        pc_inc    = (op == OP_SKZ) && zero;
        pc_load   = (op == OP_JMP);
        // Drive a cycle ahead of the write so data is settled at the edge.
        bus_drive = (op == OP_STO);
      end
      STORE: begin
        mem_rd    = aluop;
        ld_ac     = aluop;
        bus_drive = (op == OP_STO);
        mem_wr    = (op == OP_STO);
      end
      default: ;
    endcase
  end

  pc_counter #(
    .WIDTH(ADDR_WIDTH)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_data_i(ir_q[ADDR_WIDTH-1:0]),
    .pc_o       (pc_cur)
  );

  // Phases 4-7 have phase[2] set and address the instruction's operand.
  assign mem_addr = phase_q[2] ? ir_q[ADDR_WIDTH-1:0] : pc_cur;
  assign mem_data = bus_drive ? acc_in : 'z;
  assign opcode   = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign pc       = pc_cur;
  assign phase    = phase_q;

endmodule
